// File: rtl/cic_interpolator.sv
// Five-stage CIC interpolator: low-rate combs, zero-stuffing, full-rate integrators,
// then programmable arithmetic scaling and saturation to a 12-bit output.
module cic_interpolator #(
    parameter int WIDTH            = 64,
    parameter int DECIMATION_RATIO = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         gain,
    input  logic signed [11:0] s_data,
    input  logic               s_valid,
    output logic               s_ready,
    output logic signed [11:0] d_out,
    output logic               d_clk,
    output logic               underrun
);

    localparam int STAGES = 5;
    localparam logic [15:0] LAST_CNT = 16'(DECIMATION_RATIO - 1);
    localparam logic [15:0] HALF_CNT = 16'(DECIMATION_RATIO / 2);
    localparam logic [15:0] SH_MAX   = 16'(WIDTH - 12);
    localparam logic signed [WIDTH-1:0] SAT_HI = WIDTH'(2047);
    localparam logic signed [WIDTH-1:0] SAT_LO = -WIDTH'(2048);

    logic [15:0]             cnt_q, cnt_d;
    logic signed [WIDTH-1:0] in_q, in_d;
    logic [STAGES:0]         en_q, en_d;
    logic signed [WIDTH-1:0] comb_q [STAGES];
    logic signed [WIDTH-1:0] comb_d [STAGES];
    logic signed [WIDTH-1:0] dly_q [STAGES];
    logic signed [WIDTH-1:0] dly_d [STAGES];
    logic signed [WIDTH-1:0] integ_q [STAGES];
    logic signed [WIDTH-1:0] integ_d [STAGES];
    logic signed [WIDTH-1:0] stage_in [STAGES];
    logic signed [WIDTH-1:0] stuff;
    logic signed [WIDTH-1:0] scaled;
    logic [15:0]             sh;
    logic signed [11:0]      d_out_q, d_out_d;
    logic                    d_clk_q, d_clk_d;
    logic                    underrun_q, underrun_d;
    logic                    slot;

    assign slot     = (cnt_q == LAST_CNT);
    assign s_ready  = slot;
    assign d_out    = d_out_q;
    assign d_clk    = d_clk_q;
    assign underrun = underrun_q;

    always_comb begin
        stage_in[0] = in_q;
        for (int k = 1; k < STAGES; k++) stage_in[k] = comb_q[k-1];
    end

    always_comb begin
        cnt_d = slot ? 16'd0 : cnt_q + 16'd1;

        // A missed slot still launches the comb pipeline, with a zero sample.
        in_d = in_q;
        if (slot) in_d = s_valid ? {{(WIDTH-12){s_data[11]}}, s_data} : '0;
        en_d = {en_q[STAGES-1:0], slot};

        comb_d = comb_q;
        dly_d  = dly_q;
        for (int k = 0; k < STAGES; k++) begin
            if (en_q[k]) begin
                comb_d[k] = stage_in[k] - dly_q[k];
                dly_d[k]  = stage_in[k];
            end
        end

        stuff      = en_q[STAGES] ? comb_q[STAGES-1] : '0;
        integ_d[0] = integ_q[0] + stuff;
        for (int k = 1; k < STAGES; k++) integ_d[k] = integ_q[k] + integ_q[k-1];

        sh     = ({8'd0, gain} <= SH_MAX) ? SH_MAX - {8'd0, gain} : 16'd0;
        scaled = integ_q[STAGES-1] >>> sh;
        if (scaled > SAT_HI)      d_out_d = 12'sd2047;
        else if (scaled < SAT_LO) d_out_d = -12'sd2048;
        else                      d_out_d = scaled[11:0];

        d_clk_d    = (cnt_q < HALF_CNT);
        underrun_d = slot & ~s_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            in_q       <= '0;
            en_q       <= '0;
            d_out_q    <= '0;
            d_clk_q    <= 1'b0;
            underrun_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                comb_q[k]  <= '0;
                dly_q[k]   <= '0;
                integ_q[k] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            in_q       <= in_d;
            en_q       <= en_d;
            d_out_q    <= d_out_d;
            d_clk_q    <= d_clk_d;
            underrun_q <= underrun_d;
            comb_q     <= comb_d;
            dly_q      <= dly_d;
            integ_q    <= integ_d;
        end
    end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed bench for cic_interpolator: reset/phase, impulse, DC table, underrun, mid-stream reset.
module tb_cic_interpolator;

    localparam int R = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         gain = 8'd36;
    logic signed [11:0] s_data = '0;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic signed [11:0] d_out;
    logic               d_clk;
    logic               underrun;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int gain;
        int data;
        int exp;
    } vec_t;

    vec_t vecs [9];

    cic_interpolator #(.WIDTH(64), .DECIMATION_RATIO(R)) dut (
        .clk(clk), .rst_n(rst_n), .gain(gain), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .d_out(d_out), .d_clk(d_clk), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!s_ready && n < 2 * R) begin
            tick();
            n++;
        end
        if (!s_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    // After release, edge n leaves cnt = n mod R; d_clk reflects the count before it.
    task automatic check_phase(input string name);
        for (int n = 1; n < 2 * R; n++) begin
            tick();
            check({name, "_ready"}, int'(s_ready), int'((n % R) == R - 1));
            check({name, "_dclk"}, int'(d_clk), int'(((n - 1) % R) < R / 2));
        end
    endtask

    initial begin
        int imp [5];
        int mn;

        vecs[0] = '{36, 100, 100};
        vecs[1] = '{36, -2048, -2048};
        vecs[2] = '{36, 2047, 2047};
        vecs[3] = '{52, 1, 2047};
        vecs[4] = '{52, -1, -2048};
        vecs[5] = '{36, -100, -100};
        vecs[6] = '{40, 100, 1600};
        vecs[7] = '{60, 1, 2047};
        vecs[8] = '{36, 0, 0};
        imp = '{1, 5, 15, 35, 70};

        // Reset with random inputs toggling
        for (int i = 0; i < 6; i++) begin
            gain    = 8'($urandom);
            s_data  = 12'($urandom);
            s_valid = 1'($urandom);
            tick();
        end
        check("rst_dout", int'(d_out), 0);
        check("rst_ready", int'(s_ready), 0);
        check("rst_dclk", int'(d_clk), 0);
        check("rst_underrun", int'(underrun), 0);
        s_valid = 1'b1;
        rst_n   = 1'b1;
        check_phase("phase");

        // Impulse at sh = 0
        gain = 8'd52; s_data = 12'sd1; s_valid = 1'b1;
        do_reset();
        wait_ready();
        tick();
        s_data = 12'sd0;
        repeat (10) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("impulse", int'(d_out), imp[k]);
        end

        // DC table
        for (int v = 0; v < 9; v++) begin
            gain    = 8'(vecs[v].gain);
            s_data  = 12'(vecs[v].data);
            s_valid = 1'b1;
            do_reset();
            repeat (8 * R) tick();
            check("dc_settle", int'(d_out), vecs[v].exp);
            repeat (R / 2 + 3) tick();
            check("dc_hold", int'(d_out), vecs[v].exp);
        end

        // Underrun: drop one slot in a DC = 100 stream
        gain = 8'd36; s_data = 12'sd100; s_valid = 1'b1;
        do_reset();
        repeat (8 * R) tick();
        check("ur_pre", int'(d_out), 100);
        check("ur_idle", int'(underrun), 0);
        wait_ready();
        s_valid = 1'b0;
        tick();
        s_valid = 1'b1;
        check("ur_pulse", int'(underrun), 1);
        tick();
        check("ur_pulse_end", int'(underrun), 0);
        mn = 100;
        for (int i = 0; i < 5 * R + 9; i++) begin
            tick();
            if (int'(d_out) < mn) mn = int'(d_out);
        end
        check("ur_dip", int'(mn < 100), 1);
        for (int i = 0; i < R; i++) begin
            tick();
            check("ur_recover", int'(d_out), 100);
            check("ur_no_repeat", int'(underrun), 0);
        end

        // Mid-stream asynchronous reset
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_dout", int'(d_out), 0);
        check("mid_ready", int'(s_ready), 0);
        check("mid_dclk", int'(d_clk), 0);
        check("mid_underrun", int'(underrun), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        check_phase("mid_phase");
        repeat (8 * R) tick();
        check("mid_resettle", int'(d_out), 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
